// File: rtl/tpx3_rx_mux.sv
// Round-robin merge of N FWFT word streams into one tagged FWFT output buffer.
// Each grant moves at most MAX_BURST words; every stored word carries its source channel index.
module tpx3_rx_mux #(
  parameter int N_CHANNELS = 8,
  parameter int CH_ID_LSB  = 24,
  parameter int MAX_BURST  = 4,
  parameter int DEPTH      = 8,
  localparam int CH_ID_W   = $clog2(N_CHANNELS)
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_N,
  input  logic [N_CHANNELS-1:0]   CH_EN,
  input  logic [N_CHANNELS-1:0]   CH_FIFO_EMPTY,
  input  logic [32*N_CHANNELS-1:0] CH_FIFO_DATA,
  output logic [N_CHANNELS-1:0]   CH_FIFO_READ,
  input  logic                    FIFO_READ,
  output logic                    FIFO_EMPTY,
  output logic [31:0]             FIFO_DATA,
  output logic                    FIFO_FULL,
  output logic [CH_ID_W-1:0]      GRANT_CH,
  output logic [31:0]             WORD_CNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [31:0] TAG_MASK = ((32'd1 << CH_ID_W) - 32'd1) << CH_ID_LSB;
  localparam logic [CH_ID_W-1:0] LAST_CH = CH_ID_W'(N_CHANNELS - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    SCAN  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [CH_ID_W-1:0]   grant_reg, grant_next;
  logic [CH_ID_W-1:0]   rr_reg, rr_next;
  logic [7:0]           burst_cnt_reg, burst_cnt_next;

  logic [PTR_W:0]       count_reg;
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [31:0]          mem [DEPTH];
  logic [31:0]          last_pop_reg;
  logic [31:0]          word_cnt_reg;

  logic [N_CHANNELS-1:0] ch_avail;
  logic [31:0]           ch_word [N_CHANNELS];
  logic                  scan_found;
  logic [CH_ID_W-1:0]    scan_ch;
  logic [CH_ID_W-1:0]    grant_inc;
  logic [31:0]           tagged_word;
  logic                  buf_full, buf_empty;
  logic                  rd_en, push, pop;

  // Per-channel availability, head-word unpacking and read-strobe decode.
  genvar gi;
  generate
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
      assign ch_avail[gi]     = CH_EN[gi] & ~CH_FIFO_EMPTY[gi];
      assign ch_word[gi]      = CH_FIFO_DATA[32*gi +: 32];
      assign CH_FIFO_READ[gi] = rd_en && (grant_reg == CH_ID_W'(gi));
    end
  endgenerate

  assign buf_full  = (count_reg == COUNT_FULL);
  assign buf_empty = (count_reg == '0);

  // Reads depend only on registered state and channel flags, never on the readout pop,
  // so a full buffer stalls the burst even if the head is leaving this cycle.
  assign rd_en = BUS_RST_N && (state_reg == BURST) && ch_avail[grant_reg] && !buf_full;
  assign push  = rd_en;
  assign pop   = FIFO_READ && !buf_empty;

  assign grant_inc   = (grant_reg == LAST_CH) ? '0 : grant_reg + 1'b1;
  assign tagged_word = (ch_word[grant_reg] & ~TAG_MASK) |
                       ((32'(grant_reg) << CH_ID_LSB) & TAG_MASK);

  // First available channel at or after the round-robin pointer, wrapping.
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      int idx;
      idx = (int'(rr_reg) + i) % N_CHANNELS;
      if (!scan_found && ch_avail[idx]) begin
        scan_found = 1'b1;
        scan_ch    = CH_ID_W'(idx);
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_reg     <= SCAN;
      grant_reg     <= '0;
      rr_reg        <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_reg        <= rr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_next        = rr_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      SCAN: begin
        if (scan_found) begin
          grant_next     = scan_ch;
          burst_cnt_next = '0;
          state_next     = BURST;
        end
      end
      BURST: begin
        if (!ch_avail[grant_reg]) begin
          state_next = SCAN;
          rr_next    = grant_inc;
        end else if (rd_en) begin
          burst_cnt_next = burst_cnt_reg + 8'd1;
          if (burst_cnt_reg == BURST_LAST) begin
            state_next = SCAN;
            rr_next    = grant_inc;
          end
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      last_pop_reg <= '0;
      word_cnt_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + 1'b1;
        word_cnt_reg <= word_cnt_reg + 32'd1;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        last_pop_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= tagged_word;
    end
  end

  // When drained, the output keeps showing the last word handed to the readout.
  assign FIFO_DATA  = buf_empty ? last_pop_reg : mem[rd_ptr_reg];
  assign FIFO_EMPTY = buf_empty;
  assign FIFO_FULL  = buf_full;
  assign GRANT_CH   = grant_reg;
  assign WORD_CNT   = word_cnt_reg;

endmodule

// File: tb/tb_tpx3_rx_mux.sv
// Scoreboard bench for tpx3_rx_mux: modelled input FIFOs feed directed word sets,
// a forked monitor compares every popped output word against the expected queue.
module tb_tpx3_rx_mux;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   ch_en, ch_empty, ch_read;
  logic [32*N-1:0] ch_data;
  logic           fifo_read, fifo_empty, fifo_full;
  logic [31:0]    fifo_data, word_cnt;
  logic [2:0]     grant_ch;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [N][64];
  int wr_ptr [N];
  int rd_ptr [N]  = '{default: 0};
  int pop_cnt [N] = '{default: 0};
  int cyc = 0;
  int rd_total = 0;
  int last_rd_cyc = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  tpx3_rx_mux #(.N_CHANNELS(8), .CH_ID_LSB(24), .MAX_BURST(4), .DEPTH(8)) dut (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_EN(ch_en), .CH_FIFO_EMPTY(ch_empty),
    .CH_FIFO_DATA(ch_data), .CH_FIFO_READ(ch_read), .FIFO_READ(fifo_read),
    .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_FULL(fifo_full),
    .GRANT_CH(grant_ch), .WORD_CNT(word_cnt)
  );

  // Input FIFO model: FWFT heads, popped on the DUT read strobes.
  always_comb begin
    ch_empty = '0;
    ch_data  = '0;
    for (int c = 0; c < N; c++) begin
      ch_empty[c]         = (rd_ptr[c] == wr_ptr[c]);
      ch_data[32*c +: 32] = mem[c][rd_ptr[c] & 63];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (|ch_read) begin
      rd_total    <= rd_total + 1;
      last_rd_cyc <= cyc;
    end
    for (int c = 0; c < N; c++) begin
      if (ch_read[c]) begin
        rd_ptr[c]  <= rd_ptr[c] + 1;
        pop_cnt[c] <= pop_cnt[c] + 1;
      end
    end
  end

  function automatic logic [31:0] in_word(int c, int i);
    return {8'hFF, 4'h0, 4'(c), 16'(i)};
  endfunction

  // Tag field [26:24] replaced by the channel index.
  function automatic logic [31:0] exp_word(int c, int i);
    return {5'b11111, 3'(c), 4'h0, 4'(c), 16'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic load(int c, int n);
    for (int k = 0; k < n; k++) begin
      mem[c][wr_ptr[c] & 63] = in_word(c, wr_ptr[c]);
      wr_ptr[c]++;
    end
  endtask

  task automatic expect_ch(int c, int first, int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_word(c, first + k));
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && fifo_read && !fifo_empty) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected none", fifo_data);
        end else begin
          check("scoreboard", fifo_data, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_drain(string name);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d words pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic wait_pops(int c, int target);
    for (int k = 0; k < 100 && pop_cnt[c] < target; k++) tick();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, first;
    fork
      monitor();
    join_none
    for (int c = 0; c < N; c++) wr_ptr[c] = 0;
    ch_en     = '1;
    fifo_read = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full",  32'(fifo_full), 32'd0);
    check("rst_data",  fifo_data, 32'd0);
    check("rst_wcnt",  word_cnt, 32'd0);
    check("rst_read",  32'(ch_read), 32'd0);
    check("rst_grant", 32'(grant_ch), 32'd0);
    rst_n = 1'b1;
    tick();

    // Two busy channels: alternating bursts of 4, tags 0 and 3
    fifo_read = 1'b1;
    load(0, 10);
    load(3, 10);
    expect_ch(0, 0, 4); expect_ch(3, 0, 4);
    expect_ch(0, 4, 4); expect_ch(3, 4, 4);
    expect_ch(0, 8, 2); expect_ch(3, 8, 2);
    base = rd_total;
    for (int k = 0; k < 50 && rd_total == base; k++) tick();
    first = last_rd_cyc;
    for (int k = 0; k < 100 && rd_total < base + 20; k++) tick();
    check("t2_reads", 32'(rd_total - base), 32'd20);
    // 20 reads, one SCAN after each full burst, BURST+SCAN after ch0 runs dry
    check("t2_span", 32'(last_rd_cyc - first), 32'd25);
    wait_drain("t2_drain");
    check("t2_wcnt", word_cnt, 32'd20);

    // Backpressure: buffer fills with exactly DEPTH words, then resumes
    fifo_read = 1'b0;
    load(1, 20);
    expect_ch(1, 0, 20);
    base = pop_cnt[1];
    repeat (30) tick();
    check("t3_pops", 32'(pop_cnt[1] - base), 32'd8);
    check("t3_full", 32'(fifo_full), 32'd1);
    check("t3_noread", 32'(ch_read), 32'd0);
    fifo_read = 1'b1;
    wait_drain("t3_drain");
    check("t3_pops_all", 32'(pop_cnt[1] - base), 32'd20);

    // Disabled ch0 never read; disabling ch2 mid-burst ends it at once
    ch_en = 8'b1111_1110;
    load(0, 3);
    load(2, 10);
    expect_ch(2, 0, 2);
    first = pop_cnt[0];
    base  = pop_cnt[2];
    wait_pops(2, base + 2);
    ch_en[2] = 1'b0;
    #1;
    check("t4_stop_now", 32'(ch_read), 32'd0);
    repeat (20) tick();
    check("t4_ch2_pops", 32'(pop_cnt[2] - base), 32'd2);
    check("t4_ch0_pops", 32'(pop_cnt[0] - first), 32'd0);
    wait_drain("t4_drain");
    wr_ptr[0] = rd_ptr[0];
    wr_ptr[2] = rd_ptr[2];
    ch_en = '1;
    tick();

    // Push and pop together at count DEPTH-1, then FIFO_READ on an empty buffer
    fifo_read = 1'b0;
    load(4, 12);
    expect_ch(4, 0, 12);
    base = pop_cnt[4];
    repeat (30) tick();
    check("t5_full", 32'(fifo_full), 32'd1);
    check("t5_pops8", 32'(pop_cnt[4] - base), 32'd8);
    fifo_read = 1'b1;
    tick();
    tick();
    fifo_read = 1'b0;
    check("t5_pushpop_full", 32'(fifo_full), 32'd0);
    check("t5_pops9", 32'(pop_cnt[4] - base), 32'd9);
    tick();
    check("t5_refill_full", 32'(fifo_full), 32'd1);
    check("t5_pops10", 32'(pop_cnt[4] - base), 32'd10);
    fifo_read = 1'b1;
    wait_drain("t5_drain");
    repeat (3) tick();
    check("t5_empty_hold", 32'(fifo_empty), 32'd1);
    check("t5_last_data", fifo_data, exp_word(4, 11));
    check("t5_wcnt", word_cnt, 32'd54);

    // Reset mid-burst with 5 words buffered; SCAN restarts from ch0
    fifo_read = 1'b0;
    load(5, 10);
    base = pop_cnt[5];
    wait_pops(5, base + 5);
    check("t6_buffered", 32'(pop_cnt[5] - base), 32'd5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_noread", 32'(ch_read), 32'd0);
    load(6, 2);
    exp_q.delete();
    tick();
    check("t6_empty", 32'(fifo_empty), 32'd1);
    check("t6_full", 32'(fifo_full), 32'd0);
    check("t6_wcnt", word_cnt, 32'd0);
    check("t6_grant", 32'(grant_ch), 32'd0);
    check("t6_data", fifo_data, 32'd0);
    rst_n = 1'b1;
    expect_ch(5, 5, 4);
    expect_ch(6, 0, 2);
    expect_ch(5, 9, 1);
    fifo_read = 1'b1;
    wait_drain("t6_drain");
    check("t6_wcnt_after", word_cnt, 32'd7);
    check("t6_ch5_total", 32'(pop_cnt[5] - base), 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
